// File: rtl/ddr_bus_pkg.sv
// Shared types and constants for the DDR bus responder: FSM encoding, bus widths
// and the default read-timeout and error-data values.
package ddr_bus_pkg;

  localparam int DDR_ADDR_W = 24;
  localparam int MC_ADDR_W  = 22;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;

  localparam int                RD_TIMEOUT_DEFAULT = 255;
  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP,
    TURN
  } state_t;

endpackage

// File: rtl/ddr_resp_rdcache.sv
// One-entry read cache for the DDR bus responder: a tag, one data word and a valid
// bit. Write-through updates merge bytes into the entry when the tag matches.
module ddr_resp_rdcache
  import ddr_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MC_ADDR_W-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_W-1:0]    hit_data,
  input  logic [MC_ADDR_W-1:0] entry_addr,
  input  logic                 fill,
  input  logic [DATA_W-1:0]    fill_data,
  input  logic                 inval,
  input  logic                 update,
  input  logic [DATA_W-1:0]    update_data,
  input  logic [STRB_W-1:0]    update_strb
);

  logic                 valid_q;
  logic [MC_ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0]    data_q;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] nxt,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = nxt[b*8 +: 8];
    end
    return res;
  endfunction

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign hit_data = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (inval) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      valid_q <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q  <= entry_addr;
      data_q <= fill_data;
    end else if (update && valid_q && (tag_q == entry_addr)) begin
      data_q <= merge_bytes(data_q, update_data, update_strb);
    end
  end

endmodule

// File: rtl/ddr_bus_responder.sv
// Single-outstanding DDR bus responder bridging a request/ready master port to a
// memory-controller command/read-return port. Optional read cache: DDR_RESP_RDCACHE_EN.
module ddr_bus_responder
  import ddr_bus_pkg::*;
#(
  parameter int                RD_TIMEOUT = RD_TIMEOUT_DEFAULT,
  parameter logic [DATA_W-1:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                  clkrv,
  input  logic                  rst,
  input  logic [DDR_ADDR_W-1:0] ddr_addr,
  input  logic [DATA_W-1:0]     ddr_wdata,
  input  logic [STRB_W-1:0]     ddr_wstrb,
  input  logic                  ddr_valid,
  output logic                  ddr_ready,
  output logic [DATA_W-1:0]     ddr_rdata,
  output logic                  mc_cmd_valid,
  input  logic                  mc_cmd_ready,
  output logic                  mc_cmd_we,
  output logic [MC_ADDR_W-1:0]  mc_cmd_addr,
  output logic [DATA_W-1:0]     mc_cmd_wdata,
  output logic [STRB_W-1:0]     mc_cmd_wmask,
  input  logic                  mc_rd_valid,
  input  logic [DATA_W-1:0]     mc_rd_data,
  output logic                  err_timeout
);

  localparam int             CNT_W    = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [MC_ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0]    wdata_p0;
  logic [STRB_W-1:0]    wstrb_p0;

  logic capture, cnt_clr, cnt_inc, rd_take, rd_err, hit_take, cmd_accept;
  logic hit_now;
  logic [DATA_W-1:0] hit_data;
  logic addr_lsb_unused;

  assign addr_lsb_unused = ^ddr_addr[1:0];

`ifdef DDR_RESP_RDCACHE_EN
  logic cache_hit;

  ddr_resp_rdcache u_rdcache (
    .clk         (clkrv),
    .rst         (rst),
    .lookup_addr (ddr_addr[DDR_ADDR_W-1:2]),
    .hit         (cache_hit),
    .hit_data    (hit_data),
    .entry_addr  (addr_p0),
    .fill        (rd_take),
    .fill_data   (mc_rd_data),
    .inval       (rd_err),
    .update      (cmd_accept && mc_cmd_we),
    .update_data (wdata_p0),
    .update_strb (wstrb_p0)
  );

  assign hit_now = cache_hit && (ddr_wstrb == '0);
`else
  assign hit_now  = 1'b0;
  assign hit_data = '0;
`endif

  assign cmd_accept   = (state == ISSUE) && mc_cmd_ready;
  assign ddr_ready    = (state == RESP);
  assign mc_cmd_valid = (state == ISSUE);
  assign mc_cmd_we    = |wstrb_p0;
  assign mc_cmd_addr  = addr_p0;
  assign mc_cmd_wdata = wdata_p0;
  assign mc_cmd_wmask = wstrb_p0;

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    rd_take    = 1'b0;
    rd_err     = 1'b0;
    hit_take   = 1'b0;
    case (state)
      IDLE: begin
        if (ddr_valid) begin
          capture = 1'b1;
          if (hit_now) begin
            hit_take   = 1'b1;
            state_next = RESP;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mc_cmd_ready) begin
          if (mc_cmd_we) begin
            state_next = RESP;
          end else begin
            cnt_clr    = 1'b1;
            state_next = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        // Return data wins over a timeout landing in the same cycle.
        if (mc_rd_valid) begin
          rd_take    = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_LAST) begin
          rd_err     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP:    state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkrv) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ddr_rdata   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (rd_take) begin
        ddr_rdata <= mc_rd_data;
      end else if (rd_err) begin
        ddr_rdata   <= ERR_DATA;
        err_timeout <= 1'b1;
      end else if (hit_take) begin
        ddr_rdata <= hit_data;
      end
    end
  end

  // p0: request captured in IDLE, held stable while the command is outstanding.
  always_ff @(posedge clkrv) begin
    if (capture) begin
      addr_p0  <= ddr_addr[DDR_ADDR_W-1:2];
      wdata_p0 <= ddr_wdata;
      wstrb_p0 <= ddr_wstrb;
    end
  end

endmodule

// File: tb/tb_ddr_bus_responder.sv
// Bench for ddr_bus_responder: table of transactions with a response scoreboard,
// plus hand sequences for reset abandonment and (when enabled) the read cache.
module tb_ddr_bus_responder;

  localparam int TO = 8;

  logic        clkrv = 1'b0;
  logic        rst;
  logic [23:0] ddr_addr;
  logic [31:0] ddr_wdata;
  logic [3:0]  ddr_wstrb;
  logic        ddr_valid;
  logic        ddr_ready;
  logic [31:0] ddr_rdata;
  logic        mc_cmd_valid;
  logic        mc_cmd_ready;
  logic        mc_cmd_we;
  logic [21:0] mc_cmd_addr;
  logic [31:0] mc_cmd_wdata;
  logic [3:0]  mc_cmd_wmask;
  logic        mc_rd_valid;
  logic [31:0] mc_rd_data;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cmd_wait;
    int          rlat;
    logic [31:0] rret;
    bit          hit;
    logic [21:0] exp_cmd_addr;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  ddr_bus_responder #(.RD_TIMEOUT(TO), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clkrv        (clkrv),
    .rst          (rst),
    .ddr_addr     (ddr_addr),
    .ddr_wdata    (ddr_wdata),
    .ddr_wstrb    (ddr_wstrb),
    .ddr_valid    (ddr_valid),
    .ddr_ready    (ddr_ready),
    .ddr_rdata    (ddr_rdata),
    .mc_cmd_valid (mc_cmd_valid),
    .mc_cmd_ready (mc_cmd_ready),
    .mc_cmd_we    (mc_cmd_we),
    .mc_cmd_addr  (mc_cmd_addr),
    .mc_cmd_wdata (mc_cmd_wdata),
    .mc_cmd_wmask (mc_cmd_wmask),
    .mc_rd_valid  (mc_rd_valid),
    .mc_rd_data   (mc_rd_data),
    .err_timeout  (err_timeout)
  );

  always #5 clkrv = ~clkrv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every ddr_ready pulse must match one pending request.
  always @(negedge clkrv) begin
    if (ddr_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ddr_ready=1 expected 0 with nothing pending");
      end else begin
        chk("ready_rdata", ddr_rdata, sb_q.pop_front());
      end
    end
  end

  // Latency is the index of the ddr_ready cycle, the capture cycle being cycle 1.
  task automatic txn(input vec_t v, input string tag);
    int cyc;
    int n;
    logic we;
    we = (v.wstrb != 4'b0000);
    @(negedge clkrv);
    ddr_valid = 1'b1;
    ddr_addr  = v.addr;
    ddr_wdata = v.wdata;
    ddr_wstrb = v.wstrb;
    sb_q.push_back(v.exp_rdata);
    @(negedge clkrv);
    cyc = 2;
    if (v.hit) begin
      chk($sformatf("%s_hit_no_cmd", tag), 32'(mc_cmd_valid), 32'd0);
    end else begin
      chk($sformatf("%s_cmd_valid", tag), 32'(mc_cmd_valid), 32'd1);
      chk($sformatf("%s_cmd_addr", tag), 32'(mc_cmd_addr), 32'(v.exp_cmd_addr));
      chk($sformatf("%s_cmd_we", tag), 32'(mc_cmd_we), 32'(we));
      chk($sformatf("%s_cmd_wdata", tag), mc_cmd_wdata, v.wdata);
      chk($sformatf("%s_cmd_wmask", tag), 32'(mc_cmd_wmask), 32'(v.wstrb));
      for (int i = 0; i < v.cmd_wait; i++) begin
        ddr_addr    = 24'($urandom);
        ddr_wdata   = $urandom;
        ddr_wstrb   = 4'($urandom);
        mc_rd_valid = 1'b1;
        mc_rd_data  = 32'h5555_AAAA;
        @(negedge clkrv);
        cyc++;
        chk($sformatf("%s_hold_fields", tag),
            32'({mc_cmd_valid, mc_cmd_we, mc_cmd_wmask, mc_cmd_addr}),
            32'({1'b1, we, v.wstrb, v.exp_cmd_addr}));
        chk($sformatf("%s_hold_wdata", tag), mc_cmd_wdata, v.wdata);
        chk($sformatf("%s_hold_no_ready", tag), 32'(ddr_ready), 32'd0);
      end
      mc_rd_valid  = 1'b0;
      mc_cmd_ready = 1'b1;
      @(negedge clkrv);
      cyc++;
      mc_cmd_ready = 1'b0;
      if (!we && v.rlat > 0) begin
        repeat (v.rlat - 1) begin
          @(negedge clkrv);
          cyc++;
        end
        mc_rd_valid = 1'b1;
        mc_rd_data  = v.rret;
        @(negedge clkrv);
        cyc++;
        mc_rd_valid = 1'b0;
      end
    end
    n = 0;
    while (ddr_ready !== 1'b1 && n < 64) begin
      @(negedge clkrv);
      cyc++;
      n++;
    end
    if (ddr_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got no ddr_ready expected one within 64 cycles", tag);
      void'(sb_q.pop_front());
    end else begin
      chk($sformatf("%s_latency", tag), 32'(cyc), 32'(v.exp_lat));
    end
    // Valid stays high through TURN; it must not start a new command.
    @(negedge clkrv);
    chk($sformatf("%s_single_pulse", tag), 32'(ddr_ready), 32'd0);
    @(negedge clkrv);
    ddr_valid = 1'b0;
    chk($sformatf("%s_no_new_cmd", tag), 32'({mc_cmd_valid, ddr_ready}), 32'd0);
    chk($sformatf("%s_rdata_hold", tag), ddr_rdata, v.exp_rdata);
    chk($sformatf("%s_err_timeout", tag), 32'(err_timeout), 32'(v.exp_err));
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{24'h800010, 32'hA5A5_5A5A, 4'b0010, 0,  0, 32'h0,         1'b0, 22'h200004, 32'h0000_0000, 3,  1'b0};
    tbl[1] = '{24'h800010, 32'h0,         4'b0000, 0,  5, 32'h1234_5678, 1'b0, 22'h200004, 32'h1234_5678, 8,  1'b0};
    tbl[2] = '{24'h000004, 32'hDEAD_BEEF, 4'b1111, 10, 0, 32'h0,         1'b0, 22'h000001, 32'h1234_5678, 13, 1'b0};
    tbl[3] = '{24'hFFFFFF, 32'h0,         4'b0000, 2,  1, 32'hCAFE_F00D, 1'b0, 22'h3FFFFF, 32'hCAFE_F00D, 6,  1'b0};
    tbl[4] = '{24'h000123, 32'h0,         4'b0000, 0,  8, 32'h0BAD_C0DE, 1'b0, 22'h000048, 32'h0BAD_C0DE, 11, 1'b0};
    tbl[5] = '{24'h000200, 32'h0,         4'b0000, 0,  0, 32'h0,         1'b0, 22'h000080, 32'hFFFF_FFFF, 11, 1'b1};
    tbl[6] = '{24'h000300, 32'h1122_3344, 4'b1000, 0,  0, 32'h0,         1'b0, 22'h0000C0, 32'hFFFF_FFFF, 3,  1'b1};

    rst          = 1'b1;
    ddr_addr     = '0;
    ddr_wdata    = '0;
    ddr_wstrb    = '0;
    ddr_valid    = 1'b0;
    mc_cmd_ready = 1'b0;
    mc_rd_valid  = 1'b0;
    mc_rd_data   = '0;
    repeat (3) @(negedge clkrv);
    chk("reset_ready", 32'(ddr_ready), 32'd0);
    chk("reset_cmd_valid", 32'(mc_cmd_valid), 32'd0);
    chk("reset_rdata", ddr_rdata, 32'd0);
    chk("reset_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while waiting for read data abandons the read; late data is ignored.
    @(negedge clkrv);
    ddr_valid = 1'b1;
    ddr_addr  = 24'h000400;
    ddr_wstrb = 4'b0000;
    @(negedge clkrv);
    chk("abort_cmd_valid", 32'(mc_cmd_valid), 32'd1);
    mc_cmd_ready = 1'b1;
    @(negedge clkrv);
    mc_cmd_ready = 1'b0;
    ddr_valid    = 1'b0;
    @(negedge clkrv);
    rst = 1'b1;
    @(negedge clkrv);
    rst         = 1'b0;
    mc_rd_valid = 1'b1;
    mc_rd_data  = 32'h9999_9999;
    @(negedge clkrv);
    mc_rd_valid = 1'b0;
    chk("abort_no_ready", 32'(ddr_ready), 32'd0);
    chk("abort_cmd_idle", 32'(mc_cmd_valid), 32'd0);
    chk("abort_rdata", ddr_rdata, 32'd0);
    chk("abort_err_cleared", 32'(err_timeout), 32'd0);
    @(negedge clkrv);
    chk("abort_still_no_ready", 32'(ddr_ready), 32'd0);

    v = '{24'h000008, 32'h0F0F_0F0F, 4'b1111, 0, 0, 32'h0, 1'b0, 22'h000002, 32'h0000_0000, 3, 1'b0};
    txn(v, "post_reset_wr");

`ifdef DDR_RESP_RDCACHE_EN
    v = '{24'h000010, 32'h0, 4'b0000, 0, 3, 32'h1111_1111, 1'b0, 22'h000004, 32'h1111_1111, 6, 1'b0};
    txn(v, "cache_fill");
    v = '{24'h000010, 32'h0000_0077, 4'b0001, 0, 0, 32'h0, 1'b0, 22'h000004, 32'h1111_1111, 3, 1'b0};
    txn(v, "cache_wr_through");
    v = '{24'h000010, 32'h0, 4'b0000, 0, 0, 32'h0, 1'b1, 22'h000004, 32'h1111_1177, 2, 1'b0};
    txn(v, "cache_hit");
`endif

    repeat (2) @(negedge clkrv);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: got %0d left expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
